// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and data memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [3:0]            bus_be_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [31:0]           bus_wdata_o;
  logic                  bus_gnt_i;
  logic                  bus_rvalid_i;
  logic [31:0]           bus_rdata_i;
  logic                  bus_err_i;

  modport master (
    output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one req/gnt/rvalid data-bus transaction per instruction,
// byte-lane placement for stores, lane extraction and extension for loads.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           rdata_o,
  output logic                  misalign_o,
  output logic                  err_o,
  load_store_unit_if.master     bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t                state;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [7:0]            tcnt;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic                  legal;
  logic [3:0]            be_n;
  logic [31:0]           wdata_n;
  logic [7:0]            lb;
  logic [15:0]           lh;
  logic [31:0]           load_data;
  logic                  timeout_hit;

  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = bus_we_q;
  assign bus.bus_be_o    = be_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_wdata_o = wdata_q;

  // The access currently in REQ/WAIT has used up its cycle budget this cycle.
  assign timeout_hit = (tcnt + 8'd1 == TMO);

  // Width/alignment legality of the incoming request; unsigned widths are load-only.
  always_comb begin
    legal = 1'b0;
    case (funct3_i)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr_i[0];
      3'b010:  legal = (addr_i[1:0] == 2'b00);
      3'b100:  legal = ~we_i;
      3'b101:  legal = ~we_i & ~addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  // Lane enables and replicated write data; loads reuse the same enables.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_n    = 4'b0001 << addr_i[1:0];
        wdata_n = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << addr_i[1:0];
        wdata_n = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    lb = bus.bus_rdata_i[7:0];
      2'd1:    lb = bus.bus_rdata_i[15:8];
      2'd2:    lb = bus.bus_rdata_i[23:16];
      default: lb = bus.bus_rdata_i[31:24];
    endcase
    lh = off_q[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{lb[7]}}, lb};
      3'b001:  load_data = {{16{lh[15]}}, lh};
      3'b100:  load_data = {24'd0, lb};
      3'b101:  load_data = {16'd0, lh};
      default: load_data = bus.bus_rdata_i;
    endcase
  end

  // Access sequencer with all status and bus outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rdata_o    <= '0;
      misalign_o <= 1'b0;
      err_o      <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      tcnt       <= '0;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
          err_o      <= 1'b0;
          if (req_i) begin
            busy_o <= 1'b1;
            if (legal) begin
              state     <= REQ;
              we_q      <= we_i;
              f3_q      <= funct3_i;
              off_q     <= addr_i[1:0];
              tcnt      <= '0;
              bus_req_q <= 1'b1;
              bus_we_q  <= we_i;
              be_q      <= be_n;
              addr_q    <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
              wdata_q   <= wdata_n;
            end else begin
              // Illegal width/alignment never touches the bus.
              state      <= DONE;
              done_o     <= 1'b1;
              misalign_o <= 1'b1;
            end
          end
        end
        REQ, WAIT: begin
          if ((state == WAIT || bus.bus_gnt_i) && bus.bus_rvalid_i) begin
            // A response wins over a timeout landing in the same cycle.
            state     <= DONE;
            done_o    <= 1'b1;
            bus_req_q <= 1'b0;
            if (bus.bus_err_i)
              err_o <= 1'b1;
            else if (!we_q)
              rdata_o <= load_data;
          end else if (timeout_hit) begin
            state     <= DONE;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            bus_req_q <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
            if (state == REQ && bus.bus_gnt_i) begin
              state     <= WAIT;
              bus_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          busy_o     <= 1'b0;
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
          err_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a behavioural access model and a
// cycle-accurate bus responder.
module tb_load_store_unit;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        busy, done, misalign, err;
  logic [31:0] rdata;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_rdata = '0;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wdata_i(wd), .busy_o(busy), .done_o(done),
    .rdata_o(rdata), .misalign_o(misalign), .err_o(err), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stat"}, {busy, done, misalign, err, bus.bus_req_o, bus.bus_we_o,
                         bus.bus_be_o, rdata}, '0);
    chk({tag, "_bus"}, {bus.bus_addr_o, bus.bus_wdata_o}, '0);
  endtask

  // Access size in bytes, 0 for an unused width code.
  function automatic int acc_size(input logic [2:0] f);
    case (f[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_legal(input bit w, input logic [2:0] f, input logic [31:0] a);
    int s = acc_size(f);
    if (s == 0) return 1'b0;
    if (f[2] && (w || s == 4)) return 1'b0;
    if (int'(a[1:0]) % s != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
    int s = acc_size(f);
    logic [3:0] m;
    if (s == 4) return 4'hF;
    m = 4'((1 << s) - 1);
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f, input logic [31:0] d);
    int s = acc_size(f);
    if (s == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (s == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] word);
    int s = acc_size(f);
    logic [31:0] v, mask;
    if (s == 4) return word;
    v    = word >> (8 * a[1:0]);
    mask = (32'd1 << (8 * s)) - 32'd1;
    v    = v & mask;
    if (!f[2] && v[8 * s - 1]) v = v | ~mask;
    return v;
  endfunction

  // One instruction: gnt after gd stalled REQ cycles, rvalid rv cycles after gnt.
  task automatic access(input bit w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] word, input int gd,
                        input int rv, input bit berr, input bit nognt);
    bit legal    = model_legal(w, f, a);
    int r        = gd + 1 + rv;
    bit tmo      = legal && (nognt || r > TMO);
    int exp_done = !legal ? 1 : (tmo ? TMO + 1 : r + 1);
    bit exp_err  = tmo || (legal && berr);
    bit exp_req;
    @(negedge clk);
    req = 1'b1; we = w; f3 = f; addr = a; wd = d;
    for (int c = 1; c <= exp_done; c++) begin
      @(negedge clk);
      bus.bus_gnt_i    = 1'b0;
      bus.bus_rvalid_i = 1'b0;
      bus.bus_err_i    = 1'b0;
      bus.bus_rdata_i  = $urandom;
      req  = (c < exp_done) ? 1'($urandom % 2) : 1'b0;
      addr = $urandom;
      chk("busy", busy, 1'b1);
      chk("done", done, c == exp_done);
      if (c < exp_done) begin
        exp_req = legal && (nognt || c <= gd + 1);
        chk("bus_req", bus.bus_req_o, exp_req);
        chk("flags_early", {misalign, err}, 2'b00);
        if (exp_req) begin
          chk("bus_addr", bus.bus_addr_o, {a[31:2], 2'b00});
          chk("bus_be", bus.bus_be_o, model_be(f, a));
          chk("bus_we", bus.bus_we_o, w);
          if (w) chk("bus_wdata", bus.bus_wdata_o, model_wd(f, d));
        end
        if (legal && !nognt && c == gd + 1) bus.bus_gnt_i = 1'b1;
        if (legal && !nognt && c == r) begin
          bus.bus_rvalid_i = 1'b1;
          bus.bus_err_i    = berr;
          bus.bus_rdata_i  = word;
        end
      end else begin
        if (legal && !w && !exp_err) exp_rdata = model_load(f, a, word);
        chk("misalign", misalign, !legal);
        chk("err", err, exp_err);
        chk("rdata", rdata, exp_rdata);
        chk("req_at_done", bus.bus_req_o, 1'b0);
      end
    end
    @(negedge clk);
    chk("idle_after", {busy, done, misalign, err}, 4'b0000);
  endtask

  initial begin
    bus.bus_gnt_i    = 1'b0;
    bus.bus_rvalid_i = 1'b0;
    bus.bus_rdata_i  = '0;
    bus.bus_err_i    = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    access(1'b0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 1, 1'b0, 1'b0);
    access(1'b0, 3'b000, 32'h203, 0, 32'h80FF1234, 0, 1, 1'b0, 1'b0);
    access(1'b0, 3'b100, 32'h203, 0, 32'h80FF1234, 0, 1, 1'b0, 1'b0);
    access(1'b0, 3'b101, 32'h202, 0, 32'h80FF1234, 0, 1, 1'b0, 1'b0);
    access(1'b0, 3'b001, 32'h200, 0, 32'h80FF1234, 0, 0, 1'b0, 1'b0);
    access(1'b1, 3'b000, 32'h301, 32'h000000A5, 0, 0, 1, 1'b0, 1'b0);
    access(1'b1, 3'b001, 32'h302, 32'h0000BEEF, 0, 1, 2, 1'b0, 1'b0);
    access(1'b0, 3'b010, 32'h102, 0, 32'h11111111, 0, 1, 1'b0, 1'b0);
    access(1'b1, 3'b001, 32'h0F1, 32'h1234, 0, 0, 1, 1'b0, 1'b0);
    access(1'b0, 3'b011, 32'h100, 0, 32'h22222222, 0, 1, 1'b0, 1'b0);
    access(1'b0, 3'b010, 32'h400, 0, 32'h12345678, 5, 1, 1'b1, 1'b0);
    access(1'b0, 3'b010, 32'h500, 0, 32'h87654321, 0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++)
      access(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, $urandom,
             int'($urandom % 5), int'($urandom % 5), ($urandom % 8) == 0,
             ($urandom % 25) == 0);

    // Reset in the middle of a load, followed by a late response.
    @(negedge clk);
    req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h600;
    @(negedge clk);
    req = 1'b0;
    bus.bus_gnt_i = 1'b1;
    @(negedge clk);
    bus.bus_gnt_i = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    bus.bus_rvalid_i = 1'b1;
    bus.bus_rdata_i  = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.bus_rvalid_i = 1'b0;
      chk("stale_rvalid", {busy, done, rdata}, 34'd0);
    end
    access(1'b0, 3'b010, 32'h600, 0, 32'hCAFEF00D, 0, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
